keccak_absorb_buffer: RTL and testbench

- Upstream of the suffix/padding stage in the Keccak engine.
- Accepts a 64-bit message stream and packs it lane by lane into a rate-sized block buffer shaped like the state array.
- Hands each completed block to the permutation controller, which XORs it into the state.
- On the final block, supplies the byte count the padder consumes as bytes_absorbed, and emits an extra padding-only block when the message ends exactly on a rate boundary.

---
 rtl/keccak_pkg.sv | 22 ++
 rtl/keep_mask_popcount.sv | 20 ++
 rtl/keccak_absorb_buffer.sv | 184 ++++++++++++++++++
 tb/tb_keccak_absorb_buffer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak engine types and sizes: state-array geometry, rate/byte-count
// widths and the absorb-buffer FSM encoding.
package keccak_pkg;

  localparam int ROW_SIZE          = 5;
  localparam int COL_SIZE          = 5;
  localparam int LANE_SIZE         = 64;
  localparam int RATE_WIDTH        = 11;
  localparam int BYTE_ABSORB_WIDTH = 8;
  localparam int LANE_BYTES        = 8;
  localparam int MAX_RATE_LANES    = 21;

  typedef enum logic [1:0] {
    ABS_IDLE  = 2'd0,
    ABS_FILL  = 2'd1,
    ABS_HOLD  = 2'd2,
    ABS_FLUSH = 2'd3
  } absorb_state_e;

  typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] block_t;

endpackage

// File: rtl/keep_mask_popcount.sv
// Expands per-byte keep enables into a 64-bit data mask and counts the kept bytes.
module keep_mask_popcount
  import keccak_pkg::*;
(
  input  logic [LANE_BYTES-1:0] keep_i,
  output logic [LANE_SIZE-1:0]  mask_o,
  output logic [3:0]            count_o
);

  // Byte-wise mask expansion and population count.
  always_comb begin
    mask_o  = '0;
    count_o = 4'd0;
    for (int b = 0; b < LANE_BYTES; b++) begin
      mask_o[b*8 +: 8] = {8{keep_i[b]}};
      count_o          = count_o + {3'd0, keep_i[b]};
    end
  end

endmodule

// File: rtl/keccak_absorb_buffer.sv
// Packs a 64-bit message stream lane by lane into a rate-sized block, hands
// finished blocks downstream and appends a padding-only block on exact-rate ends.
module keccak_absorb_buffer
  import keccak_pkg::*;
#(
  parameter int MAX_LANES = MAX_RATE_LANES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [RATE_WIDTH-1:0]        rate_i,
  input  logic [63:0]                  msg_data_i,
  input  logic [7:0]                   msg_keep_i,
  input  logic                         msg_valid_i,
  input  logic                         msg_last_i,
  output logic                         msg_ready_o,
  output block_t                       blk_data_o,
  output logic [BYTE_ABSORB_WIDTH-1:0] blk_bytes_o,
  output logic                         blk_last_o,
  output logic                         blk_valid_o,
  input  logic                         blk_ready_i,
  output logic                         busy_o
);

  localparam int LCW = $clog2(MAX_LANES);

  absorb_state_e                  state_q, state_d;
  block_t                         buf_q, buf_d;
  logic [LCW-1:0]                 lane_cnt_q, lane_cnt_d;
  logic [LCW-1:0]                 nlanes_q, nlanes_d;
  logic [RATE_WIDTH-1:0]          rate_q, rate_d;
  logic [BYTE_ABSORB_WIDTH-1:0]   bytes_q, bytes_d;
  logic                           last_q, last_d;
  logic                           pend_q, pend_d;

  logic [LANE_SIZE-1:0] keep_mask_s;
  logic [3:0]           keep_cnt_s;
  logic                 accept_s;
  logic                 lane_end_s;
  logic                 full_tail_s;

  keep_mask_popcount u_keep (
    .keep_i  (msg_keep_i),
    .mask_o  (keep_mask_s),
    .count_o (keep_cnt_s)
  );

  assign accept_s    = (state_q == ABS_FILL) && msg_valid_i;
  assign lane_end_s  = (lane_cnt_q == (nlanes_q - LCW'(1)));
  // A final word that exactly fills the rate leaves no room for padding.
  assign full_tail_s = lane_end_s && msg_last_i && (msg_keep_i == 8'hFF);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ABS_IDLE;
      buf_q      <= '0;
      lane_cnt_q <= '0;
      nlanes_q   <= '0;
      rate_q     <= '0;
      bytes_q    <= '0;
      last_q     <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      lane_cnt_q <= lane_cnt_d;
      nlanes_q   <= nlanes_d;
      rate_q     <= rate_d;
      bytes_q    <= bytes_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ABS_IDLE: begin
        if (start_i) state_d = ABS_FILL;
        else         state_d = ABS_IDLE;
      end
      ABS_FILL: begin
        if (accept_s && (msg_last_i || lane_end_s)) state_d = ABS_HOLD;
        else                                        state_d = ABS_FILL;
      end
      ABS_HOLD: begin
        if (!blk_ready_i) state_d = ABS_HOLD;
        else if (last_q)  state_d = ABS_IDLE;
        else if (pend_q)  state_d = ABS_FLUSH;
        else              state_d = ABS_FILL;
      end
      ABS_FLUSH: begin
        if (blk_ready_i) state_d = ABS_IDLE;
        else             state_d = ABS_FLUSH;
      end
      default: state_d = ABS_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    msg_ready_o = 1'b0;
    blk_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      ABS_IDLE:  busy_o      = 1'b0;
      ABS_FILL:  msg_ready_o = 1'b1;
      ABS_HOLD:  blk_valid_o = 1'b1;
      ABS_FLUSH: blk_valid_o = 1'b1;
      default:   busy_o      = 1'b0;
    endcase
  end

  // Lane writer, byte counter and block flags.
  always_comb begin
    buf_d      = buf_q;
    lane_cnt_d = lane_cnt_q;
    nlanes_d   = nlanes_q;
    rate_d     = rate_q;
    bytes_d    = bytes_q;
    last_d     = last_q;
    pend_d     = pend_q;
    case (state_q)
      ABS_IDLE: begin
        if (start_i) begin
          rate_d     = rate_i;
          nlanes_d   = LCW'(rate_i >> 6);
          lane_cnt_d = '0;
          buf_d      = '0;
          bytes_d    = '0;
          last_d     = 1'b0;
          pend_d     = 1'b0;
        end else begin
          lane_cnt_d = lane_cnt_q;
        end
      end
      ABS_FILL: begin
        if (accept_s) begin
          for (int c = 0; c < COL_SIZE; c++) begin
            for (int r = 0; r < ROW_SIZE; r++) begin
              if ((r + ROW_SIZE * c) == int'(lane_cnt_q)) begin
                buf_d[r][c] = msg_data_i & keep_mask_s;
              end else begin
                buf_d[r][c] = buf_q[r][c];
              end
            end
          end
          bytes_d    = bytes_q + BYTE_ABSORB_WIDTH'(keep_cnt_s);
          lane_cnt_d = lane_cnt_q + LCW'(1);
          last_d     = msg_last_i && !full_tail_s;
          pend_d     = full_tail_s;
        end else begin
          lane_cnt_d = lane_cnt_q;
        end
      end
      ABS_HOLD: begin
        if (blk_ready_i) begin
          buf_d      = '0;
          bytes_d    = '0;
          lane_cnt_d = '0;
          // The padding-only block that follows is the final one.
          last_d     = pend_q && !last_q;
          pend_d     = 1'b0;
        end else begin
          lane_cnt_d = lane_cnt_q;
        end
      end
      ABS_FLUSH: begin
        if (blk_ready_i) last_d = 1'b0;
        else             last_d = last_q;
      end
      default: begin
        lane_cnt_d = '0;
      end
    endcase
  end

  assign blk_data_o  = buf_q;
  assign blk_bytes_o = bytes_q;
  assign blk_last_o  = last_q;

endmodule

// File: tb/tb_keccak_absorb_buffer.sv
// Scoreboard bench for keccak_absorb_buffer: stimulus pushes expected blocks,
// a negedge monitor pops and compares on every block handshake.
module tb_keccak_absorb_buffer;
  import keccak_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         start_i;
  logic [RATE_WIDTH-1:0]        rate_i;
  logic [63:0]                  msg_data_i;
  logic [7:0]                   msg_keep_i;
  logic                         msg_valid_i;
  logic                         msg_last_i;
  logic                         msg_ready_o;
  block_t                       blk_data_o;
  logic [BYTE_ABSORB_WIDTH-1:0] blk_bytes_o;
  logic                         blk_last_o;
  logic                         blk_valid_o;
  logic                         blk_ready_i;
  logic                         busy_o;

  typedef struct {
    block_t     data;
    logic [7:0] bytes;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   stall_cycles = 0;

  always #5 clk = ~clk;

  keccak_absorb_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .rate_i      (rate_i),
    .msg_data_i  (msg_data_i),
    .msg_keep_i  (msg_keep_i),
    .msg_valid_i (msg_valid_i),
    .msg_last_i  (msg_last_i),
    .msg_ready_o (msg_ready_o),
    .blk_data_o  (blk_data_o),
    .blk_bytes_o (blk_bytes_o),
    .blk_last_o  (blk_last_o),
    .blk_valid_o (blk_valid_o),
    .blk_ready_i (blk_ready_i),
    .busy_o      (busy_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_blk(input string nm, input block_t act, input block_t exp);
    bit shown;
    shown = 1'b0;
    checks++;
    if (act !== exp) begin
      failures++;
      for (int i = 0; i < 25; i++) begin
        if (!shown && act[i%5][i/5] !== exp[i%5][i/5]) begin
          shown = 1'b1;
          $display("FAIL %s lane=%0d actual=%h required=%h", nm, i, act[i%5][i/5], exp[i%5][i/5]);
        end
      end
    end
  endtask

  // Downstream: hold ready low for stall_cycles cycles of each presented block.
  initial begin
    int wait_cnt;
    wait_cnt    = 0;
    blk_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (blk_valid_o) begin
        if (wait_cnt >= stall_cycles) blk_ready_i = 1'b1;
        else begin
          blk_ready_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        blk_ready_i = 1'b0;
        wait_cnt    = 0;
      end
    end
  end

  // Monitor: compare each consumed block against the scoreboard.
  initial begin
    exp_t                         e;
    bit                           prev_wait;
    block_t                       prev_data;
    logic [BYTE_ABSORB_WIDTH-1:0] prev_bytes;
    logic                         prev_last;
    prev_wait = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && blk_valid_o) begin
        chk("ready_in_hold", {63'd0, msg_ready_o}, 64'd0);
        if (prev_wait) begin
          chk_blk("hold_data_stable", blk_data_o, prev_data);
          chk("hold_bytes_stable", {56'd0, blk_bytes_o}, {56'd0, prev_bytes});
          chk("hold_last_stable", {63'd0, blk_last_o}, {63'd0, prev_last});
        end
        if (blk_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_block actual=1 required=0");
          end else begin
            e = exp_q.pop_front();
            chk_blk("blk_data", blk_data_o, e.data);
            chk("blk_bytes", {56'd0, blk_bytes_o}, {56'd0, e.bytes});
            chk("blk_last", {63'd0, blk_last_o}, {63'd0, e.last});
          end
        end
      end
      prev_wait  = rst_n && blk_valid_o && !blk_ready_i;
      prev_data  = blk_data_o;
      prev_bytes = blk_bytes_o;
      prev_last  = blk_last_o;
    end
  end

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy_o && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("end_in_idle", {63'd0, busy_o}, 64'd0);
  endtask

  task automatic start_msg(input int rate);
    wait_idle();
    start_i = 1'b1;
    rate_i  = RATE_WIDTH'(rate);
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Drive nwords words (byte j of word k = k*8+j) and push expected blocks.
  task automatic send(input int rate, input int nwords, input logic [7:0] lastkeep,
                      input bit do_last, input int poke_after);
    block_t      eb;
    int          lane, nb, nlanes, g;
    logic [63:0] w, m;
    logic [7:0]  kp;
    bit          lst, full_tail;
    exp_t        e;
    nlanes = rate / 64;
    eb = '0;
    lane = 0;
    nb = 0;
    for (int k = 1; k <= nwords; k++) begin
      for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(k * 8 + j);
      lst = do_last && (k == nwords);
      kp  = lst ? lastkeep : 8'hFF;
      msg_valid_i = 1'b1;
      msg_data_i  = w;
      msg_keep_i  = kp;
      msg_last_i  = lst;
      g = 0;
      @(negedge clk);
      while (!msg_ready_o && g < 200) begin
        g++;
        @(negedge clk);
      end
      if (!msg_ready_o) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=0 required=1 word=%0d", k);
        break;
      end
      @(posedge clk);
      #1;
      for (int j = 0; j < 8; j++) begin
        m[j*8 +: 8] = {8{kp[j]}};
        nb += int'(kp[j]);
      end
      eb[lane%5][lane/5] = w & m;
      lane++;
      if (lst || lane == nlanes) begin
        full_tail = (lane == nlanes) && lst && (kp == 8'hFF);
        e.data = eb;
        e.bytes = 8'(nb);
        e.last = lst && !full_tail;
        exp_q.push_back(e);
        if (full_tail) begin
          e.data = '0;
          e.bytes = 8'd0;
          e.last = 1'b1;
          exp_q.push_back(e);
        end
        eb = '0;
        lane = 0;
        nb = 0;
      end
      if (k == poke_after) begin
        start_i = 1'b1;
        rate_i  = 11'd1344;
        @(posedge clk);
        #1;
        start_i = 1'b0;
      end
    end
    msg_valid_i = 1'b0;
    msg_last_i  = 1'b0;
    msg_keep_i  = 8'h00;
    msg_data_i  = 64'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start_i = 1'b0;
    rate_i = '0;
    msg_data_i = 64'd0;
    msg_keep_i = 8'h00;
    msg_valid_i = 1'b0;
    msg_last_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, msg_ready_o}, 64'd0);
    chk("rst_valid", {63'd0, blk_valid_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_bytes", {56'd0, blk_bytes_o}, 64'd0);
    chk_blk("rst_data", blk_data_o, '0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // SHA3-256 short message, tail of 3 bytes.
    stall_cycles = 3;
    start_msg(1088);
    send(1088, 3, 8'h07, 1'b1, 0);
    @(negedge clk);
    chk("t1_bytes", {56'd0, blk_bytes_o}, 64'd19);
    chk("t1_last", {63'd0, blk_last_o}, 64'd1);
    chk("t1_lane2", blk_data_o[2][0], 64'h00000000001A1918);
    chk("t1_lane0", blk_data_o[0][0], 64'h0F0E0D0C0B0A0908);

    // Exact rate boundary: full block then padding-only block.
    stall_cycles = 0;
    start_msg(1088);
    send(1088, 17, 8'hFF, 1'b1, 0);

    // Rate 1344 with back-pressure at every block.
    stall_cycles = 5;
    start_msg(1344);
    send(1344, 30, 8'hFF, 1'b1, 0);

    // Zero-length tail.
    stall_cycles = 0;
    start_msg(1088);
    send(1088, 1, 8'h00, 1'b1, 0);

    // Partial last word landing in the final lane.
    start_msg(576);
    send(576, 9, 8'h3F, 1'b1, 0);

    // Reset mid-FILL, then restart at rate 576.
    start_msg(1088);
    send(1088, 5, 8'hFF, 1'b0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {63'd0, msg_ready_o}, 64'd0);
    chk("mid_rst_valid", {63'd0, blk_valid_o}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy_o}, 64'd0);
    chk("mid_rst_last", {63'd0, blk_last_o}, 64'd0);
    chk_blk("mid_rst_data", blk_data_o, '0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_msg(576);
    send(576, 4, 8'hFF, 1'b1, 0);

    // start_i pulsed while a block is held must not change the rate.
    stall_cycles = 2;
    start_msg(576);
    send(576, 18, 8'hFF, 1'b1, 9);

    wait_idle();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
